// File: rtl/tristate_bus_driver_pkg.sv
// Shared types and helpers for the multi-channel tristate bus driver.
// Holds the arbiter FSM encoding, the index-width helper and default parameters.
package tbd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    TURN  = 2'b10
  } state_t;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_CHANNELS   = 4;
  localparam int DEF_TURNAROUND = 1;
  localparam int DEF_HOLD_LIMIT = 0;

  // Bits needed to index n items, never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tristate_bus_driver_rr_pick.sv
// Round-robin selector: first set request at or after ptr, wrapping.
// Purely combinational, zero latency; no backpressure.
module rr_pick
  import tbd_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int IDXW     = clog2(DEF_CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [IDXW-1:0]     ptr,
  output logic [IDXW-1:0]     winner,
  output logic                any_req
);

  always_comb begin
    logic            found;
    int              sum;
    logic [IDXW-1:0] idx;
    winner = '0;
    found  = 1'b0;
    sum    = 0;
    idx    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sum = int'(ptr) + i;
      if (sum >= CHANNELS) sum = sum - CHANNELS;
      idx = IDXW'(sum);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/tristate_bus_driver.sv
// Round-robin arbiter driving one shared tristate bus from CHANNELS sources.
// Latency: grant and data one edge after request; bus_out reloads owner data every edge.
// Backpressure: requesters wait at level; TURNAROUND Z cycles always separate owners.
module tristate_bus_driver
  import tbd_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int TURNAROUND = DEF_TURNAROUND,
  parameter int HOLD_LIMIT = DEF_HOLD_LIMIT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHANNELS-1:0]        req,
  input  logic [CHANNELS*WIDTH-1:0]  data_in,
  output logic [CHANNELS-1:0]        grant,
  output wire  [WIDTH-1:0]           bus_out,
  output logic                       bus_en,
  output logic [clog2(CHANNELS)-1:0] owner,
  output logic                       busy
);

  localparam int IDXW     = clog2(CHANNELS);
  localparam int HOLD_SAT = (HOLD_LIMIT > 0) ? HOLD_LIMIT - 1 : 0;
  localparam int HW       = clog2(HOLD_SAT + 1);

  localparam logic [HW-1:0]   HOLD_SAT_V = HW'(HOLD_SAT);
  localparam logic [3:0]      TURN_LOAD  = 4'(TURNAROUND - 1);
  localparam logic [IDXW-1:0] LAST_CH    = IDXW'(CHANNELS - 1);

  state_t                state_q, state_d;
  logic [CHANNELS-1:0]   grant_q, grant_d;
  logic [IDXW-1:0]       owner_q, owner_d;
  logic [WIDTH-1:0]      bus_q, bus_d;
  logic [IDXW-1:0]       ptr_q, ptr_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [3:0]            turn_q, turn_d;

  logic [IDXW-1:0]       winner;
  logic                  any_req;
  logic                  hold_force;
  logic                  do_arb;
  logic                  do_rel;
  logic [WIDTH-1:0]      ch_dat [CHANNELS];

  // Per-channel slices so only the selected channel reaches the bus register.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_slice
    assign ch_dat[c] = data_in[c*WIDTH +: WIDTH];
  end

  rr_pick #(
    .CHANNELS(CHANNELS),
    .IDXW    (IDXW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (winner),
    .any_req(any_req)
  );

  // hold_q counts completed DRIVE cycles; reaching HOLD_SAT means this is the last allowed one.
  assign hold_force = (HOLD_LIMIT != 0) && (hold_q >= HOLD_SAT_V) && (|(req & ~grant_q));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    bus_d   = bus_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    do_arb  = 1'b0;
    do_rel  = 1'b0;

    case (state_q)
      IDLE: do_arb = 1'b1;
      DRIVE: begin
        if (!req[owner_q] || hold_force) begin
          do_rel = 1'b1;
        end else begin
          bus_d = ch_dat[owner_q];
          if (hold_q < HOLD_SAT_V) hold_d = hold_q + HW'(1);
        end
      end
      TURN: begin
        if (turn_q == 4'd0) do_arb = 1'b1;
        else                turn_d = turn_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase

    if (do_rel) begin
      state_d = TURN;
      grant_d = '0;
      owner_d = '0;
      bus_d   = '0;
      turn_d  = TURN_LOAD;
    end

    if (do_arb) begin
      if (any_req) begin
        state_d         = DRIVE;
        grant_d         = '0;
        grant_d[winner] = 1'b1;
        owner_d         = winner;
        bus_d           = ch_dat[winner];
        hold_d          = '0;
        ptr_d           = (winner == LAST_CH) ? '0 : winner + IDXW'(1);
      end else begin
        state_d = IDLE;
        grant_d = '0;
        owner_d = '0;
        bus_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      bus_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      bus_q   <= bus_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
    end
  end

  assign grant   = grant_q;
  assign owner   = owner_q;
  assign bus_en  = |grant_q;
  assign busy    = (state_q != IDLE);
  assign bus_out = bus_en ? bus_q : {WIDTH{1'bz}};

endmodule
